pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic_if.sv | 46 ++++
 rtl/pipe_stage_elastic.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_if
// Groups the upstream handshake, downstream handshake, forwarding tap and
// stall-counter signals of one elastic pipeline stage.
//   slave  : the stage itself (accepts in_*, produces out_*/fwd_*/stall_cnt)
//   master : the surrounding logic (producer, consumer, hazard unit)
// Upstream   : in_valid, in_ready, in_payload, in_rd, in_regw
// Downstream : out_valid, out_ready, out_payload, out_rd, out_regw
// Control    : flush, stall_clr
// Observation: fwd_valid, fwd_rd, fwd_data, stall_cnt
// -----------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
  parameter int PAYLOAD_W = 160,
  parameter int RD_W      = 5,
  parameter int FWD_W     = 32,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [RD_W-1:0]      in_rd;
  logic                 in_regw;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [RD_W-1:0]      out_rd;
  logic                 out_regw;
  logic                 fwd_valid;
  logic [RD_W-1:0]      fwd_rd;
  logic [FWD_W-1:0]     fwd_data;
  logic [CNT_W-1:0]     stall_cnt;
  logic                 stall_clr;

  modport slave (
    input  in_valid, in_payload, in_rd, in_regw, flush, out_ready, stall_clr,
    output in_ready, out_valid, out_payload, out_rd, out_regw,
           fwd_valid, fwd_rd, fwd_data, stall_cnt
  );

  modport master (
    output in_valid, in_payload, in_rd, in_regw, flush, out_ready, stall_clr,
    input  in_ready, out_valid, out_payload, out_rd, out_regw,
           fwd_valid, fwd_rd, fwd_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic pipeline register with a two-entry skid buffer (main entry M drives
// the outputs, skid entry S catches the beat accepted while in_ready is still
// high on the edge that fills the stage). in_ready is a flop so there is no
// combinational path from out_ready back to in_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipe_stage_elastic_if.slave (handshakes, flush, forwarding tap,
//          stall counter and its clear)
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing held, out_valid=0, in_ready=1
// ONE   | M holds the head beat, in_ready=1
// TWO   | M holds the head beat, S holds the next one, in_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
  parameter int PAYLOAD_W = 160,
  parameter int RD_W      = 5,
  parameter int FWD_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_elastic_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_in_ready;

  logic [PAYLOAD_W-1:0] r_m_payload;
  logic [RD_W-1:0]      r_m_rd;
  logic                 r_m_regw;
  logic [PAYLOAD_W-1:0] r_s_payload;
  logic [RD_W-1:0]      r_s_rd;
  logic                 r_s_regw;

  logic [CNT_W-1:0]     r_stall_cnt;

  logic                 w_out_valid;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_load_m_in;
  logic                 w_load_m_s;
  logic                 w_load_s;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_load_m_in = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_m_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_s    = 1'b1;
          w_state_nxt = TWO;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_out_fire) begin
          w_load_m_s  = 1'b1;
          w_state_nxt = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush discards any beat accepted this cycle; a head beat leaving on
    // out_fire has already been sampled downstream, so nothing else to do.
    if (bus.flush) begin
      w_state_nxt = EMPTY;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_payload <= '0;
      r_m_rd      <= '0;
      r_m_regw    <= 1'b0;
      r_s_payload <= '0;
      r_s_rd      <= '0;
      r_s_regw    <= 1'b0;
    end else begin
      if (w_load_m_in) begin
        r_m_payload <= bus.in_payload;
        r_m_rd      <= bus.in_rd;
        r_m_regw    <= bus.in_regw;
      end else if (w_load_m_s) begin
        r_m_payload <= r_s_payload;
        r_m_rd      <= r_s_rd;
        r_m_regw    <= r_s_regw;
      end
      if (w_load_s) begin
        r_s_payload <= bus.in_payload;
        r_s_rd      <= bus.in_rd;
        r_s_regw    <= bus.in_regw;
      end
    end
  end

  // Saturating back-pressure counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_payload = r_m_payload;
  assign bus.out_rd      = r_m_rd;
  // M contents survive a flush, so the write enable must be valid-gated.
  assign bus.out_regw    = r_m_regw & w_out_valid;
  assign bus.fwd_valid   = w_out_valid & r_m_regw & (r_m_rd != '0);
  assign bus.fwd_rd      = r_m_rd;
  assign bus.fwd_data    = r_m_payload[FWD_W-1:0];
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Directed bench for pipe_stage_elastic (CNT_W=4 so saturation is reachable).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;
  localparam int PAYLOAD_W = 160;
  localparam int RD_W      = 5;
  localparam int FWD_W     = 32;
  localparam int CNT_W     = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipe_stage_elastic_if #(
    .PAYLOAD_W(PAYLOAD_W), .RD_W(RD_W), .FWD_W(FWD_W), .CNT_W(CNT_W)
  ) bus ();

  pipe_stage_elastic #(
    .PAYLOAD_W(PAYLOAD_W), .RD_W(RD_W), .FWD_W(FWD_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs,
                     input logic [PAYLOAD_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},    bus.in_ready,    1);
    chk({tag, ".out_valid"},   bus.out_valid,   0);
    chk({tag, ".out_payload"}, bus.out_payload, 0);
    chk({tag, ".out_rd"},      bus.out_rd,      0);
    chk({tag, ".out_regw"},    bus.out_regw,    0);
    chk({tag, ".fwd_valid"},   bus.fwd_valid,   0);
    chk({tag, ".fwd_rd"},      bus.fwd_rd,      0);
    chk({tag, ".fwd_data"},    bus.fwd_data,    0);
    chk({tag, ".stall_cnt"},   bus.stall_cnt,   0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_payload = '0;
    bus.in_rd      = '0;
    bus.in_regw    = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.stall_clr  = 1'b0;

    #2;
    chk_reset_vals("rst");

    // Stream 1,2,3 with out_ready held high.
    #5;
    rst = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'd1;
    cyc();
    chk("st.v1", bus.out_valid, 1);
    chk("st.p1", bus.out_payload, 160'd1);
    bus.in_payload = 160'd2;
    cyc();
    chk("st.p2", bus.out_payload, 160'd2);
    bus.in_payload = 160'd3;
    cyc();
    chk("st.p3", bus.out_payload, 160'd3);
    chk("st.rdy", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    cyc();
    chk("st.empty", bus.out_valid, 0);
    chk("st.cnt", bus.stall_cnt, 0);

    // Back-pressure fill with A, B, C.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'hA;
    cyc();
    chk("bp.A", bus.out_payload, 160'hA);
    chk("bp.rdy1", bus.in_ready, 1);
    bus.in_payload = 160'hB;
    cyc();
    chk("bp.rdy0", bus.in_ready, 0);
    chk("bp.headA", bus.out_payload, 160'hA);
    bus.in_payload = 160'hC;
    cyc();
    chk("bp.hold", bus.in_ready, 0);
    chk("bp.headA2", bus.out_payload, 160'hA);
    chk("bp.cnt2", bus.stall_cnt, 2);
    bus.out_ready = 1'b1;
    cyc();
    chk("bp.B", bus.out_payload, 160'hB);
    chk("bp.rdyup", bus.in_ready, 1);
    cyc();
    chk("bp.C", bus.out_payload, 160'hC);
    chk("bp.Cv", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    cyc();
    chk("bp.empty", bus.out_valid, 0);
    chk("bp.cnt", bus.stall_cnt, 2);

    // Flush while in TWO with in_valid=1 and out_ready=0.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_regw    = 1'b1;
    bus.in_rd      = 5'd3;
    bus.in_payload = 160'h11;
    cyc();
    bus.in_payload = 160'h22;
    cyc();
    chk("fl.two", bus.in_ready, 0);
    chk("fl.fwdpre", bus.fwd_valid, 1);
    bus.in_payload = 160'h33;
    bus.flush      = 1'b1;
    cyc();
    chk("fl.ov", bus.out_valid, 0);
    chk("fl.fwd", bus.fwd_valid, 0);
    chk("fl.regw", bus.out_regw, 0);
    chk("fl.rdy", bus.in_ready, 1);
    chk("fl.cnt", bus.stall_cnt, 4);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("fl.gone", bus.out_valid, 0);

    // Flush in ONE drops a beat offered in the same cycle.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'h44;
    cyc();
    chk("f1.p44", bus.out_payload, 160'h44);
    bus.in_payload = 160'h55;
    bus.flush      = 1'b1;
    cyc();
    chk("f1.ov", bus.out_valid, 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    chk("f1.gone", bus.out_valid, 0);
    chk("f1.cnt", bus.stall_cnt, 5);

    // Forwarding tap.
    bus.in_valid   = 1'b1;
    bus.in_payload = {128'h0, 32'hDEADBEEF};
    bus.in_rd      = 5'd7;
    bus.in_regw    = 1'b1;
    cyc();
    chk("fw.valid", bus.fwd_valid, 1);
    chk("fw.rd", bus.fwd_rd, 7);
    chk("fw.data", bus.fwd_data, 32'hDEADBEEF);
    chk("fw.regw", bus.out_regw, 1);
    bus.out_ready = 1'b1;
    bus.in_rd     = 5'd0;
    cyc();
    chk("fw.rd0", bus.fwd_valid, 0);
    chk("fw.rd0regw", bus.out_regw, 1);
    bus.in_rd   = 5'd7;
    bus.in_regw = 1'b0;
    cyc();
    chk("fw.nowr", bus.fwd_valid, 0);
    chk("fw.nowrrd", bus.fwd_rd, 7);
    chk("fw.nowrregw", bus.out_regw, 0);
    bus.in_valid = 1'b0;
    cyc();
    chk("fw.empty", bus.fwd_valid, 0);
    chk("fw.cnt", bus.stall_cnt, 5);

    // Counter saturation at 15 and clear-over-increment.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'h66;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat.15", bus.stall_cnt, 15);
    cyc();
    chk("sat.hold", bus.stall_cnt, 15);
    bus.stall_clr = 1'b1;
    cyc();
    chk("sat.clr", bus.stall_cnt, 0);
    bus.stall_clr = 1'b0;
    cyc();
    chk("sat.resume", bus.stall_cnt, 1);

    // Async reset while in TWO.
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'h77;
    cyc();
    chk("ar.two", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("ar");
    #1;
    rst = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_payload = 160'h88;
    cyc();
    chk("ar.first", bus.out_payload, 160'h88);
    chk("ar.v", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    cyc();
    chk("ar.drain", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
